// File: rtl/mux_scan.sv
// mux_scan: registered N-channel, W-bit selector with direct, scan, hold
// and single-step modes. The selected channel index and its data are
// registered together, so out and cur_ch always change on the same edge.
module mux_scan #(
    parameter int unsigned CH      = 4,
    parameter int unsigned W       = 2,
    parameter int unsigned SELW    = 2,
    parameter int unsigned DWELL   = 50000000,
    parameter int unsigned DWELL_W = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CH*W-1:0]   data_in,
    input  logic [SELW-1:0]   sel_in,
    input  logic [1:0]        mode,
    input  logic              step,
    output logic [W-1:0]      out,
    output logic [SELW-1:0]   cur_ch,
    output logic              chg,
    output logic              err
);

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'b00,
        MODE_SCAN   = 2'b01,
        MODE_HOLD   = 2'b10,
        MODE_STEP   = 2'b11
    } mode_e;

    // Extra bit so a power-of-two CH is still representable in the compare.
    localparam logic [SELW:0]      CH_L     = (SELW+1)'(CH);
    localparam logic [SELW-1:0]    LAST_CH  = SELW'(CH - 1);
    localparam logic [DWELL_W-1:0] CNT_LAST = DWELL_W'(DWELL - 1);

    logic [W-1:0]       r_out;
    logic [SELW-1:0]    r_cur_ch;
    logic               r_chg;
    logic               r_err;
    logic [DWELL_W-1:0] r_cnt;
    logic               r_step_q;
    logic               r_in_scan;

    mode_e              w_mode;
    logic               w_sel_ok;
    logic [SELW-1:0]    w_adv;
    logic [SELW-1:0]    w_nxt;
    logic               w_err;
    logic [DWELL_W-1:0] w_cnt;
    logic               w_upd;
    logic [W-1:0]       w_sel_data;

    assign w_mode   = mode_e'(mode);
    assign w_sel_ok = ({1'b0, sel_in} < CH_L);
    // Wrap by compare so CH need not be a power of two.
    assign w_adv    = (r_cur_ch == LAST_CH) ? '0 : r_cur_ch + SELW'(1);

    // Next channel, error flag and dwell count for the mode sampled this cycle.
    always_comb begin
        w_nxt = r_cur_ch;
        w_err = r_err;
        w_cnt = '0;
        w_upd = 1'b1;
        case (w_mode)
            MODE_DIRECT: begin
                if (w_sel_ok) begin
                    w_nxt = sel_in;
                    w_err = 1'b0;
                end else begin
                    w_err = 1'b1;
                end
            end
            MODE_SCAN: begin
                w_err = 1'b0;
                if (!r_in_scan) begin
                    w_cnt = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_nxt = w_adv;
                    w_cnt = '0;
                end else begin
                    w_cnt = r_cnt + DWELL_W'(1);
                end
            end
            MODE_HOLD: begin
                w_upd = 1'b0;
            end
            MODE_STEP: begin
                w_err = 1'b0;
                if (step && !r_step_q) begin
                    w_nxt = w_adv;
                end
            end
            default: begin
                w_upd = 1'b1;
            end
        endcase
    end

    // Route the next channel's data so it lands on the same edge as its index.
    always_comb begin
        w_sel_data = '0;
        for (int unsigned k = 0; k < CH; k++) begin
            if (w_nxt == SELW'(k)) begin
                w_sel_data = data_in[k*W +: W];
            end
        end
    end

    // State and registered outputs; hold mode freezes channel and data only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out     <= '0;
            r_cur_ch  <= '0;
            r_chg     <= 1'b0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
            r_step_q  <= 1'b1;
            r_in_scan <= 1'b0;
        end else begin
            r_step_q  <= step;
            r_in_scan <= (w_mode == MODE_SCAN);
            r_cnt     <= w_cnt;
            r_err     <= w_err;
            r_chg     <= (w_nxt != r_cur_ch);
            if (w_upd) begin
                r_cur_ch <= w_nxt;
                r_out    <= w_sel_data;
            end
        end
    end

    assign out    = r_out;
    assign cur_ch = r_cur_ch;
    assign chg    = r_chg;
    assign err    = r_err;

endmodule

// File: tb/tb_mux_scan.sv
// Bench for mux_scan (CH=3, W=4, DWELL=4): fixed vector table, directed
// multi-cycle sequences and a randomized run, all checked against a
// time-based reference model.
module tb_mux_scan;

    localparam int CH    = 3;
    localparam int DWELL = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] data_in;
    logic [1:0]  sel_in;
    logic [1:0]  mode;
    logic        step;
    logic [3:0]  out;
    logic [1:0]  cur_ch;
    logic        chg;
    logic        err;

    always #5 clk = ~clk;

    mux_scan #(
        .CH(3),
        .W(4),
        .SELW(2),
        .DWELL(4),
        .DWELL_W(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data_in(data_in),
        .sel_in(sel_in),
        .mode(mode),
        .step(step),
        .out(out),
        .cur_ch(cur_ch),
        .chg(chg),
        .err(err)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: in scan mode the channel is derived from elapsed time
    // since scan entry rather than from a dwell counter.
    int m_out = 0, m_ch = 0, m_chg = 0, m_err = 0;
    int m_prevstep = 1, m_prevmode = -1;
    int m_t = 0, m_t0 = 0, m_ch0 = 0;

    function automatic int chdata(input logic [11:0] d, input int k);
        return int'((d >> (k * 4)) & 12'hF);
    endfunction

    task automatic model_step();
        int nxt;
        if (rst) begin
            m_out = 0; m_ch = 0; m_chg = 0; m_err = 0;
            m_prevstep = 1; m_prevmode = -1;
        end else begin
            nxt = m_ch;
            case (int'(mode))
                0: begin
                    if (int'(sel_in) < CH) begin
                        nxt = int'(sel_in);
                        m_err = 0;
                    end else begin
                        m_err = 1;
                    end
                end
                1: begin
                    m_err = 0;
                    if (m_prevmode != 1) begin
                        m_t0  = m_t;
                        m_ch0 = m_ch;
                    end
                    nxt = (m_ch0 + (m_t - m_t0) / DWELL) % CH;
                end
                3: begin
                    m_err = 0;
                    if (step && m_prevstep == 0) nxt = (m_ch + 1) % CH;
                end
                default: ;
            endcase
            m_chg = (nxt != m_ch) ? 1 : 0;
            if (int'(mode) != 2) begin
                m_ch  = nxt;
                m_out = chdata(data_in, nxt);
            end
            m_prevstep = int'(step);
            m_prevmode = int'(mode);
        end
        m_t++;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        chk({tag, ".model.out"},    32'(out),    32'(m_out));
        chk({tag, ".model.cur_ch"}, 32'(cur_ch), 32'(m_ch));
        chk({tag, ".model.chg"},    32'(chg),    32'(m_chg));
        chk({tag, ".model.err"},    32'(err),    32'(m_err));
    endtask

    task automatic apply(input logic r, input logic [1:0] md, input logic [1:0] s,
                         input logic st, input logic [11:0] d,
                         input logic [3:0] eo, input logic [1:0] ec,
                         input logic eg, input logic ee, input string tag);
        rst = r; mode = md; sel_in = s; step = st; data_in = d;
        cycle(tag);
        chk({tag, ".out"},    32'(out),    32'(eo));
        chk({tag, ".cur_ch"}, 32'(cur_ch), 32'(ec));
        chk({tag, ".chg"},    32'(chg),    32'(eg));
        chk({tag, ".err"},    32'(err),    32'(ee));
    endtask

    typedef struct {
        logic        rst;
        logic [1:0]  mode;
        logic [1:0]  sel;
        logic        step;
        logic [11:0] data;
        logic [3:0]  e_out;
        logic [1:0]  e_ch;
        logic        e_chg;
        logic        e_err;
        string       tag;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [1:0] md, input logic [1:0] s,
                                input logic st, input logic [11:0] d,
                                input logic [3:0] eo, input logic [1:0] ec,
                                input logic eg, input logic ee, input string tag);
        vec_t v;
        v.rst = r; v.mode = md; v.sel = s; v.step = st; v.data = d;
        v.e_out = eo; v.e_ch = ec; v.e_chg = eg; v.e_err = ee; v.tag = tag;
        return v;
    endfunction

    vec_t tbl[11];

    initial begin
        logic [1:0]  ech;
        logic [3:0]  eo;
        logic [11:0] d;

        rst = 1'b1; mode = 2'b11; sel_in = 2'd0; step = 1'b1; data_in = 12'hCBA;

        // Reset with button held, then direct-mode selection and range errors.
        tbl[0]  = mk(1, 2'd3, 2'd0, 1, 12'hCBA, 4'h0, 2'd0, 0, 0, "rst0");
        tbl[1]  = mk(1, 2'd3, 2'd0, 1, 12'hCBA, 4'h0, 2'd0, 0, 0, "rst1");
        tbl[2]  = mk(0, 2'd3, 2'd0, 1, 12'hCBA, 4'hA, 2'd0, 0, 0, "post_rst_held0");
        tbl[3]  = mk(0, 2'd3, 2'd0, 1, 12'hCBA, 4'hA, 2'd0, 0, 0, "post_rst_held1");
        tbl[4]  = mk(0, 2'd0, 2'd0, 0, 12'hCBA, 4'hA, 2'd0, 0, 0, "dir_sel0");
        tbl[5]  = mk(0, 2'd0, 2'd2, 0, 12'hCBA, 4'hC, 2'd2, 1, 0, "dir_sel2");
        tbl[6]  = mk(0, 2'd0, 2'd2, 0, 12'hCBA, 4'hC, 2'd2, 0, 0, "dir_sel2_stable");
        tbl[7]  = mk(0, 2'd0, 2'd3, 0, 12'hCBA, 4'hC, 2'd2, 0, 1, "dir_sel3_err");
        tbl[8]  = mk(0, 2'd0, 2'd3, 0, 12'hCBA, 4'hC, 2'd2, 0, 1, "dir_sel3_err_hold");
        tbl[9]  = mk(0, 2'd0, 2'd1, 0, 12'hCBA, 4'hB, 2'd1, 1, 0, "dir_sel1");
        tbl[10] = mk(0, 2'd0, 2'd1, 0, 12'hCBA, 4'hB, 2'd1, 0, 0, "dir_sel1_stable");

        for (int i = 0; i < 11; i++) begin
            apply(tbl[i].rst, tbl[i].mode, tbl[i].sel, tbl[i].step, tbl[i].data,
                  tbl[i].e_out, tbl[i].e_ch, tbl[i].e_chg, tbl[i].e_err, tbl[i].tag);
        end

        // Scan from ch1: 1,2,0 each for DWELL cycles, ch2 data changes mid-dwell.
        for (int i = 0; i <= 12; i++) begin
            d   = (i >= 6) ? 12'h5BA : 12'hCBA;
            ech = 2'((1 + i / 4) % 3);
            eo  = (ech == 2'd0) ? 4'hA : (ech == 2'd1) ? 4'hB : ((i >= 6) ? 4'h5 : 4'hC);
            apply(0, 2'd1, 2'd1, 0, d, eo, ech, (i > 0 && i % 4 == 0), 0, "scan");
        end

        // Hold on ch0 while its data changes, then resume scan.
        apply(0, 2'd0, 2'd0, 0, 12'h5BA, 4'hA, 2'd0, 1, 0, "dir_to_ch0");
        for (int i = 0; i < 10; i++) begin
            apply(0, 2'd2, 2'd0, 0, 12'h5BF, 4'hA, 2'd0, 0, 0, "hold");
        end
        for (int i = 0; i <= 4; i++) begin
            ech = (i < 4) ? 2'd0 : 2'd1;
            eo  = (i < 4) ? 4'hF : 4'hB;
            apply(0, 2'd1, 2'd0, 0, 12'h5BF, eo, ech, (i == 4), 0, "rescan");
        end

        // Step mode: one short and two long presses from ch2.
        apply(0, 2'd0, 2'd2, 0, 12'h5BF, 4'h5, 2'd2, 1, 0, "dir_to_ch2");
        apply(0, 2'd3, 2'd2, 0, 12'h5BF, 4'h5, 2'd2, 0, 0, "step_idle");
        apply(0, 2'd3, 2'd2, 1, 12'h5BF, 4'hF, 2'd0, 1, 0, "step_p1");
        for (int i = 0; i < 2; i++)
            apply(0, 2'd3, 2'd2, 0, 12'h5BF, 4'hF, 2'd0, 0, 0, "step_gap1");
        for (int i = 0; i < 5; i++)
            apply(0, 2'd3, 2'd2, 1, 12'h5BF, 4'hB, 2'd1, (i == 0), 0, "step_p2");
        for (int i = 0; i < 2; i++)
            apply(0, 2'd3, 2'd2, 0, 12'h5BF, 4'hB, 2'd1, 0, 0, "step_gap2");
        for (int i = 0; i < 5; i++)
            apply(0, 2'd3, 2'd2, 1, 12'h5BF, 4'h5, 2'd2, (i == 0), 0, "step_p3");
        apply(0, 2'd3, 2'd2, 0, 12'h5BF, 4'h5, 2'd2, 0, 0, "step_gap3");

        // Entering step mode with the button already held must not advance.
        apply(0, 2'd0, 2'd2, 1, 12'h5BF, 4'h5, 2'd2, 0, 0, "dir_btn_held");
        for (int i = 0; i < 3; i++)
            apply(0, 2'd3, 2'd2, 1, 12'h5BF, 4'h5, 2'd2, 0, 0, "enter_step_held");

        // Reset two cycles into a dwell on ch2, then scan restarts from ch0.
        for (int i = 0; i < 3; i++)
            apply(0, 2'd1, 2'd2, 0, 12'h5BF, 4'h5, 2'd2, 0, 0, "scan_pre_rst");
        apply(1, 2'd1, 2'd2, 0, 12'h5BF, 4'h0, 2'd0, 0, 0, "rst_mid_scan");
        for (int i = 0; i <= 4; i++) begin
            ech = (i < 4) ? 2'd0 : 2'd1;
            eo  = (i < 4) ? 4'hF : 4'hB;
            apply(0, 2'd1, 2'd2, 0, 12'h5BF, eo, ech, (i == 4), 0, "scan_post_rst");
        end

        // Randomized run against the model only.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(15) == 0) mode = 2'($urandom_range(3));
            if ($urandom_range(3) == 0) step = ~step;
            sel_in  = 2'($urandom_range(3));
            data_in = 12'($urandom);
            rst     = ($urandom_range(63) == 0);
            cycle("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mux_scan.md
# mux_scan

Parametrised, registered N-channel, W-bit selector with four operating modes: direct select, automatic round-robin scan, frozen hold, and manual single-step. It generalises the board-level 4-to-1 2-bit switch multiplexer so that any channel count and width can be routed to LEDs or seven-segment displays. Channel selection can come from switches, advance on a timer, or advance on a button press. It sits between the board inputs (sw/button) and the display outputs in top.

## Interface
Parameters:
- CH, 4, number of input channels (≥2)
- W, 2, bits per channel
- SELW, 2, width of channel index; must satisfy 2^SELW ≥ CH
- DWELL, 50000000, clock cycles each channel is shown in scan mode (≥2)
- DWELL_W, 26, counter width; must satisfy 2^DWELL_W ≥ DWELL

Ports:
- clk  in  1  system clock; one clock domain
- rst  in  1  synchronous, active-high reset
- data_in  in  CH*W  channel k occupies bits [k*W +: W]
- sel_in  in  SELW  channel index used in direct mode
- mode  in  2  00 direct, 01 scan, 10 hold, 11 step
- step  in  1  level input (button); rising edge advances the channel in step mode
- out  out  W  registered selected data
- cur_ch  out  SELW  registered index of the channel currently routed
- chg  out  1  one-cycle pulse in the cycle after cur_ch changes value
- err  out  1  registered flag: sel_in ≥ CH seen in direct mode

## Operation
- Definitions:
  - nxt = next-cycle channel index.
  - adv = cur_ch + 1, wrapping from CH-1 to 0. Wrap is by compare, not by bit overflow, so CH need not be a power of 2.
- Direct (00):
  - If sel_in < CH: nxt = sel_in and err ← 0.
  - Otherwise: nxt = cur_ch (retain the current channel) and err ← 1.
- Scan (01):
  - Dwell counter cnt increments each cycle.
  - When cnt == DWELL-1: nxt = adv and cnt ← 0.
  - On the first cycle in scan mode (previous mode ≠ 01), cnt ← 0 and there is no advance.
  - err ← 0.
- Hold (10):
  - nxt = cur_ch.
  - out is frozen: it does not track data_in.
  - err retains its value.
- Step (11):
  - A rising edge of step (step=1 and step_q=0, where step_q is step registered one cycle) gives nxt = adv. Otherwise nxt = cur_ch.
  - One advance per edge, regardless of how long step is held.
  - err ← 0.
- Output update (all modes except hold), every cycle:
  - cur_ch ← nxt
  - out ← data_in[nxt*W +: W], i.e. the new channel's data appears in the same edge as the index.
- chg ← (nxt ≠ cur_ch); it is computed in every mode.
- cnt runs only in scan mode. In every other mode cnt is held at 0.
- step_q is updated in all modes, so switching into step mode while step is held does not produce an advance.
- A mode change takes effect on the edge at which the new mode is sampled. There is no draining or handshake.

## Timing
- Reset values (rst sampled high at an edge): out=0, cur_ch=0, chg=0, err=0, cnt=0, step_q=1.
  - step_q resets to 1, so a button held through reset causes no advance.
- Reset has priority over every mode and can be applied mid-scan or mid-step. The first post-reset cycle behaves like the first cycle of the current mode.
- Latency is 1 clock for each of these paths to out, cur_ch and err:
  - data_in → out
  - sel_in → cur_ch / out
  - step edge → cur_ch
- chg is high for exactly the one cycle in which the new cur_ch is first visible.
- Scan period: each channel is shown for exactly DWELL cycles in steady state. From scan entry, the first advance occurs DWELL cycles after the entry cycle.
- If mode leaves scan and later returns, dwell timing restarts; channel position is kept.
- No combinational path from any input to any output.

## Test plan
Bench parameters: CH=3, W=4, SELW=2, DWELL=4. data_in = {4'hC, 4'hB, 4'hA} (ch0=A).
1. Reset check: assert rst 2 cycles while step=1 and mode=11 → out=0, cur_ch=0, chg=0, err=0. After release, no advance while step stays high.
2. Direct mode:
   - sel_in 0→2 → one cycle later cur_ch=2, out=C, chg pulse of 1 cycle.
   - sel_in=3 → cur_ch stays 2, out=C, err=1.
   - sel_in=1 → out=B, err=0.
3. Scan mode: mode=01 from cur_ch=1 → cur_ch sequence 1,2,0,1, each value held exactly 4 cycles; wrap 2→0 asserts chg. Change ch2 data to 5 mid-scan → out shows 5 while cur_ch=2.
4. Hold mode: mode=10 while out=A, then change data_in ch0 to F → out stays A and cur_ch is unchanged for 10 cycles. Return to 01 → first advance 4 cycles later.
5. Step mode:
   - Three step pulses, one 1-cycle and two of 5 cycles, starting from cur_ch=2 → sequence 0,1,2. Exactly one chg per pulse.
   - Step held high while switching into mode 11 → no advance.
6. Reset mid-scan: assert rst when cnt=2 and cur_ch=2 → all outputs take reset values the next cycle. After release with mode=01, the first advance to ch1 occurs 4 cycles after the first post-reset cycle.
